// File: rtl/mu0_control_if.sv
// mu0_control_if: control-unit <-> datapath/memory signal bundle.
// master = control unit, slave = datapath side.
interface mu0_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             acc_15;
    logic             accz;
    logic             mem_ready;
    logic             acc_ce;
    logic             acc_oe;
    logic             pc_ce;
    logic             pc_sel;
    logic             ir_ce;
    logic             asel;
    logic             bsel;
    logic [1:0]       alu_fs;
    logic             mem_rd;
    logic             mem_wr;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    modport master (
        input  opcode, acc_15, accz, mem_ready,
        output acc_ce, acc_oe, pc_ce, pc_sel, ir_ce, asel, bsel, alu_fs,
               mem_rd, mem_wr, halted, instr_count
    );
    modport slave (
        output opcode, acc_15, accz, mem_ready,
        input  acc_ce, acc_oe, pc_ce, pc_sel, ir_ce, asel, bsel, alu_fs,
               mem_rd, mem_wr, halted, instr_count
    );
endinterface

// File: rtl/mu0_control.sv
// mu0_control: MU0 reset/fetch/execute/halt controller with retired-instruction counter.
// Define MU0_MEM_HANDSHAKE_EN to make memory states wait on mem_ready.
module mu0_control #(
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    mu0_control_if.master bus
);
    localparam logic [1:0] S_RST = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_HALT = 2'd3;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             rdy, fetch, exec, mem_op, is_sto, jmp_take, exec_done;
`ifdef MU0_MEM_HANDSHAKE_EN
    assign rdy = bus.mem_ready;
`else
    assign rdy = 1'b1;
`endif
    assign fetch     = state == S_FETCH;
    assign exec      = state == S_EXEC;
    assign mem_op    = bus.opcode[3:2] == 2'b00;
    assign is_sto    = bus.opcode == 4'd1;
    assign jmp_take  = bus.opcode == 4'd4 || (bus.opcode == 4'd5 && !bus.acc_15) ||
                       (bus.opcode == 4'd6 && !bus.accz);
    // Non-memory opcodes always finish in one EXEC cycle
    assign exec_done = exec && (!mem_op || rdy);
    assign bus.asel        = exec && mem_op;
    assign bus.bsel        = fetch;
    assign bus.alu_fs      = fetch ? 2'b11 : (exec && bus.opcode == 4'd2) ? 2'b01 :
                             (exec && bus.opcode == 4'd3) ? 2'b10 : 2'b00;
    assign bus.mem_rd      = fetch || (exec && mem_op && !is_sto);
    assign bus.mem_wr      = exec && is_sto;
    assign bus.acc_oe      = exec && is_sto;
    assign bus.acc_ce      = exec && mem_op && !is_sto && rdy;
    assign bus.ir_ce       = fetch && rdy;
    assign bus.pc_ce       = (fetch && rdy) || (exec && jmp_take);
    assign bus.pc_sel      = exec && jmp_take;
    assign bus.halted      = state == S_HALT;
    assign bus.instr_count = count;
    always_comb begin
        state_nxt = state == S_RST ? S_FETCH :
                    fetch ? (rdy ? S_EXEC : S_FETCH) :
                    exec ? (!exec_done ? S_EXEC : bus.opcode == 4'd7 ? S_HALT : S_FETCH) :
                    S_HALT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (exec_done) count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: table-driven scoreboard bench for mu0_control (CNT_W=4 for wrap checks).
module tb_mu0_control;
    localparam int CNT_W = 4;
    // {acc_ce, acc_oe, pc_ce, pc_sel, ir_ce, asel, bsel, alu_fs, mem_rd, mem_wr, halted}
    localparam logic [11:0] NONE   = 12'b0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [11:0] FETCH  = 12'b0_0_1_0_1_0_1_11_1_0_0;
    localparam logic [11:0] FWAIT  = 12'b0_0_0_0_0_0_1_11_1_0_0;
    localparam logic [11:0] LDA    = 12'b1_0_0_0_0_1_0_00_1_0_0;
    localparam logic [11:0] LWAIT  = 12'b0_0_0_0_0_1_0_00_1_0_0;
    localparam logic [11:0] ADD    = 12'b1_0_0_0_0_1_0_01_1_0_0;
    localparam logic [11:0] SUB    = 12'b1_0_0_0_0_1_0_10_1_0_0;
    localparam logic [11:0] STO    = 12'b0_1_0_0_0_1_0_00_0_1_0;
    localparam logic [11:0] JMP    = 12'b0_0_1_1_0_0_0_00_0_0_0;
    localparam logic [11:0] HALTED = 12'b0_0_0_0_0_0_0_00_0_0_1;

    typedef struct {
        string            name;
        logic [3:0]       op;
        logic             a15;
        logic             az;
        logic             rdy;
        logic [11:0]      outs;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mu0_control_if #(.CNT_W(CNT_W)) bus ();
    mu0_control #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vec_t q[$];
    vec_t tbl[$];
    int n_checks = 0;
    int n_fail = 0;

    function automatic vec_t v(string name, logic [3:0] op, logic a15, logic az, logic rdy,
                               logic [11:0] outs, logic [CNT_W-1:0] cnt);
        vec_t r;
        r.name = name; r.op = op; r.a15 = a15; r.az = az; r.rdy = rdy; r.outs = outs; r.cnt = cnt;
        return r;
    endfunction

    function automatic logic [11:0] outs_now();
        return {bus.acc_ce, bus.acc_oe, bus.pc_ce, bus.pc_sel, bus.ir_ce, bus.asel, bus.bsel,
                bus.alu_fs, bus.mem_rd, bus.mem_wr, bus.halted};
    endfunction

    task automatic compare();
        vec_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = q.pop_front();
        if (outs_now() !== e.outs || bus.instr_count !== e.cnt) begin
            n_fail++;
            $display("FAIL %s: got outs=%b count=%0d, expected outs=%b count=%0d",
                     e.name, outs_now(), bus.instr_count, e.outs, e.cnt);
        end
    endtask

    task automatic drive(vec_t x);
        bus.opcode = x.op; bus.acc_15 = x.a15; bus.accz = x.az; bus.mem_ready = x.rdy;
        q.push_back(x);
    endtask

    task automatic apply(vec_t x);
        drive(x);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(v("in_reset", 4'h1, 1'b0, 1'b0, 1'b1, NONE, '0));
        apply(v("in_reset_hold", 4'h4, 1'b0, 1'b0, 1'b1, NONE, '0));
        rst_n = 1'b1;
        apply(v("rst_cycle", 4'h0, 1'b0, 1'b0, 1'b1, NONE, '0));
    endtask

    initial begin
        tbl.push_back(v("fetch_lda", 4'h0, 0, 0, 1, FETCH, 4'd0));
        tbl.push_back(v("exec_lda",  4'h0, 0, 0, 1, LDA,   4'd0));
        tbl.push_back(v("fetch_add", 4'h2, 0, 0, 1, FETCH, 4'd1));
        tbl.push_back(v("exec_add",  4'h2, 0, 0, 1, ADD,   4'd1));
        tbl.push_back(v("fetch_sto", 4'h1, 0, 0, 1, FETCH, 4'd2));
        tbl.push_back(v("exec_sto",  4'h1, 0, 0, 1, STO,   4'd2));
        tbl.push_back(v("fetch_jmp", 4'h4, 0, 0, 1, FETCH, 4'd3));
        tbl.push_back(v("exec_jmp",  4'h4, 1, 1, 1, JMP,   4'd3));
        tbl.push_back(v("fetch_jge", 4'h5, 1, 0, 1, FETCH, 4'd4));
        tbl.push_back(v("jge_neg",   4'h5, 1, 0, 1, NONE,  4'd4));
        tbl.push_back(v("fetch_jge", 4'h5, 0, 0, 1, FETCH, 4'd5));
        tbl.push_back(v("jge_pos",   4'h5, 0, 1, 1, JMP,   4'd5));
        tbl.push_back(v("fetch_jne", 4'h6, 0, 1, 1, FETCH, 4'd6));
        tbl.push_back(v("jne_zero",  4'h6, 0, 1, 1, NONE,  4'd6));
        tbl.push_back(v("fetch_jne", 4'h6, 0, 0, 1, FETCH, 4'd7));
        tbl.push_back(v("jne_nz",    4'h6, 1, 0, 1, JMP,   4'd7));
        tbl.push_back(v("fetch_sub", 4'h3, 0, 0, 1, FETCH, 4'd8));
        tbl.push_back(v("exec_sub",  4'h3, 0, 0, 1, SUB,   4'd8));
        tbl.push_back(v("fetch_nop", 4'hA, 0, 0, 1, FETCH, 4'd9));
        tbl.push_back(v("exec_nop",  4'hA, 0, 0, 1, NONE,  4'd9));
        tbl.push_back(v("fetch_stp", 4'h7, 0, 0, 1, FETCH, 4'd10));
        tbl.push_back(v("exec_stp",  4'h7, 0, 0, 1, NONE,  4'd10));
        tbl.push_back(v("halt",      4'h0, 0, 0, 1, HALTED, 4'd11));
        tbl.push_back(v("halt_hold", 4'h4, 0, 0, 1, HALTED, 4'd11));
        bus.opcode = 4'h0; bus.acc_15 = 1'b0; bus.accz = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        foreach (tbl[i]) apply(tbl[i]);
`ifdef MU0_MEM_HANDSHAKE_EN
        do_reset();
        for (int i = 0; i < 3; i++) apply(v("hs_fetch_wait", 4'h0, 0, 0, 0, FWAIT, 4'd0));
        apply(v("hs_fetch_ready", 4'h0, 0, 0, 1, FETCH, 4'd0));
        for (int i = 0; i < 3; i++) apply(v("hs_lda_wait", 4'h0, 0, 0, 0, LWAIT, 4'd0));
        apply(v("hs_lda_ready", 4'h0, 0, 0, 1, LDA, 4'd0));
        apply(v("hs_next_fetch", 4'h4, 0, 0, 1, FETCH, 4'd1));
        apply(v("hs_jmp_no_wait", 4'h4, 0, 0, 0, JMP, 4'd1));
        apply(v("hs_after_jmp", 4'h0, 0, 0, 1, FETCH, 4'd2));
`else
        do_reset();
        apply(v("nohs_fetch_ignores_ready", 4'h2, 0, 0, 0, FETCH, 4'd0));
        apply(v("nohs_add_ignores_ready", 4'h2, 0, 0, 0, ADD, 4'd0));
        apply(v("nohs_next_fetch", 4'h0, 0, 0, 0, FETCH, 4'd1));
`endif
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(v("wrap_fetch", 4'h0, 0, 0, 1, FETCH, CNT_W'(i)));
            apply(v("wrap_nop", 4'(8 + (i % 8)), 0, 0, 1, NONE, CNT_W'(i)));
        end
        apply(v("wrap_to_zero", 4'h0, 0, 0, 1, FETCH, 4'd0));
        do_reset();
        apply(v("sto_fetch", 4'h1, 0, 0, 1, FETCH, 4'd0));
        drive(v("sto_waiting", 4'h1, 0, 0, 0, STO, 4'd0));
        @(negedge clk);
        compare();
        #1;
        rst_n = 1'b0;
        #1;
        drive(v("sto_reset_drops_wr", 4'h1, 0, 0, 0, NONE, 4'd0));
        compare();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(v("post_reset_rst", 4'h1, 0, 0, 1, NONE, 4'd0));
        apply(v("post_reset_fetch", 4'h1, 0, 0, 1, FETCH, 4'd0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
